// File: rtl/uart_tx_frame_fsm.sv
// rtl/uart_tx_frame_fsm.sv - UART transmit framer: start, LSB-first data, optional parity, stop.
// Drives an external serial parity calculator (clear at frame start, one pulse per data bit).
module uart_tx_frame_fsm #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_TYPE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  par_clr,
    output logic                  par_data,
    input  logic                  par_in
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic          PAR_INV   = 1'(PARITY_TYPE);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state;
    logic [BW-1:0]         baud_cnt;
    logic [IW-1:0]         bit_idx;
    logic [IW-1:0]         next_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign next_idx  = bit_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            par_clr   <= 1'b0;
            par_data  <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            par_clr  <= 1'b0;
            par_data <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift_reg <= tx_data;
                        state     <= START;
                        tx_out    <= 1'b0;
                        busy      <= 1'b1;
                        tx_ready  <= 1'b0;
                        par_clr   <= 1'b1;
                        baud_cnt  <= '0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx_out   <= shift_reg[0];
                        par_data <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            // Last pulse reached the calculator CLKS_PER_BIT-1 cycles ago, so par_in is settled.
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                tx_out <= par_in ^ PAR_INV;
                            end else begin
                                state  <= STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            bit_idx  <= next_idx;
                            tx_out   <= shift_reg[next_idx];
                            par_data <= shift_reg[next_idx];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        tx_out   <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_out   <= 1'b1;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_fsm.sv
// tb/tb_uart_tx_frame_fsm.sv - scoreboard bench for uart_tx_frame_fsm over four parameter sets.
module tb_uart_tx_frame_fsm;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] tx_data_a  [4];
    logic       tx_valid_a [4];
    logic       tx_ready_a [4];
    logic       tx_out_a   [4];
    logic       busy_a     [4];
    logic       par_clr_a  [4];
    logic       par_data_a [4];
    logic       par_in_a   [4];

    typedef struct {
        int         inst;
        logic [11:0] bits;
    } frame_t;

    frame_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Config 0: even parity, 1: odd parity, 2: no parity, 3: 5-bit data at 2 clks/bit.
    function automatic int dw_of(int g);
        return (g == 3) ? 5 : 8;
    endfunction
    function automatic int cpb_of(int g);
        return (g == 3) ? 2 : 4;
    endfunction
    function automatic int pe_of(int g);
        return (g == 2) ? 0 : 1;
    endfunction
    function automatic int pt_of(int g);
        return (g == 1) ? 1 : 0;
    endfunction

    function automatic frame_t make_frame(int g, logic [8:0] d);
        frame_t f;
        logic   p;
        f.inst    = g;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        p = 1'(pt_of(g));
        for (int i = 0; i < dw_of(g); i++) begin
            f.bits[1 + i] = d[i];
            p = p ^ d[i];
        end
        if (pe_of(g) != 0) f.bits[1 + dw_of(g)] = p;
        return f;
    endfunction

    generate
        for (genvar g = 0; g < 4; g++) begin : inst
            localparam int DW  = dw_of(g);
            localparam int CPB = cpb_of(g);
            localparam int PE  = pe_of(g);
            localparam int PT  = pt_of(g);
            localparam int FL  = (2 + DW + PE) * CPB;

            uart_tx_frame_fsm #(
                .DATA_WIDTH(DW),
                .CLKS_PER_BIT(CPB),
                .PARITY_EN(PE),
                .PARITY_TYPE(PT)
            ) dut (
                .clk(clk),
                .reset(rst_n),
                .tx_data(tx_data_a[g][DW-1:0]),
                .tx_valid(tx_valid_a[g]),
                .tx_ready(tx_ready_a[g]),
                .tx_out(tx_out_a[g]),
                .busy(busy_a[g]),
                .par_clr(par_clr_a[g]),
                .par_data(par_data_a[g]),
                .par_in(par_in_a[g])
            );

            // Serial parity calculator the framer feeds.
            always @(posedge clk or negedge rst_n) begin
                if (!rst_n)            par_in_a[g] <= 1'b0;
                else if (par_clr_a[g]) par_in_a[g] <= 1'b0;
                else                   par_in_a[g] <= par_in_a[g] ^ par_data_a[g];
            end

            initial begin : mon
                int     k;
                bit     act;
                frame_t cur;
                logic   exp_line;
                logic   exp_pd;
                k   = 0;
                act = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        act = 1'b0;
                    end else begin
                        if (!act && busy_a[g]) begin
                            if (sb.size() == 0) begin
                                check("unexpected_frame", 32'(g), 32'hFFFF_FFFF);
                            end else begin
                                cur = sb.pop_front();
                                check("sb_inst", 32'(cur.inst), 32'(g));
                                act = 1'b1;
                                k   = 0;
                            end
                        end
                        if (act) begin
                            if (k < FL) begin
                                exp_line = cur.bits[k / CPB];
                                exp_pd   = (k % CPB == 0 && k >= CPB && k < (1 + DW) * CPB) ? cur.bits[k / CPB] : 1'b0;
                                check("line", 32'(tx_out_a[g]), 32'(exp_line));
                                check("busy_ready_clr_pd",
                                      32'({busy_a[g], tx_ready_a[g], par_clr_a[g], par_data_a[g]}),
                                      32'({1'b1, 1'b0, (k == 0), exp_pd}));
                                k++;
                            end else begin
                                check("idle_gap",
                                      32'({tx_out_a[g], busy_a[g], tx_ready_a[g], par_clr_a[g], par_data_a[g]}),
                                      32'b10100);
                                act = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    // Called just after a negedge; returns the cycle count right after the accepting edge.
    task automatic send(int g, logic [8:0] d, bit hold, output int acc);
        int w;
        w = 0;
        tx_data_a[g]  = d;
        tx_valid_a[g] = 1'b1;
        while (!tx_ready_a[g] && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!tx_ready_a[g]) begin
            check("accept_timeout", 32'd0, 32'd1);
            tx_valid_a[g] = 1'b0;
            acc = cyc;
        end else begin
            sb.push_back(make_frame(g, d));
            @(posedge clk);
            #1;
            acc = cyc;
            if (!hold) tx_valid_a[g] = 1'b0;
        end
    endtask

    task automatic wait_idle(int g);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            #1;
            w++;
        end while (!(tx_ready_a[g] && !busy_a[g] && sb.size() == 0) && w < 500);
        if (!(tx_ready_a[g] && !busy_a[g] && sb.size() == 0)) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int acc;
        int rel;
        int acc1;
        int acc2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_valid_a[i] = 1'b0;
            tx_data_a[i]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check("reset_state",
                  32'({tx_out_a[i], tx_ready_a[i], busy_a[i], par_clr_a[i], par_data_a[i]}), 32'b11000);

        #1 rst_n = 1'b1;
        rel = cyc;
        send(0, 9'h0A5, 1'b0, acc);
        check("first_accept_latency", 32'(acc - rel), 32'd1);
        wait_idle(0);
        send(0, 9'h007, 1'b0, acc);
        wait_idle(0);
        send(0, 9'h000, 1'b0, acc);
        wait_idle(0);

        send(1, 9'h0A5, 1'b0, acc);
        wait_idle(1);
        send(1, 9'h000, 1'b0, acc);
        wait_idle(1);

        send(2, 9'h0FF, 1'b0, acc);
        wait_idle(2);

        send(3, 9'h015, 1'b0, acc);
        wait_idle(3);

        send(0, 9'h03C, 1'b1, acc1);
        tx_data_a[0] = 9'h05A;
        repeat (10) @(negedge clk);
        #1;
        send(0, 9'h0C3, 1'b0, acc2);
        check("b2b_period", 32'(acc2 - acc1), 32'd45);
        wait_idle(0);

        // Abort a frame in the first cycle of data bit 0 (a par_data pulse).
        send(0, 9'h0A5, 1'b0, acc);
        repeat (5) @(negedge clk);
        #2;
        check("pd_before_reset", 32'(par_data_a[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset",
              32'({tx_out_a[0], tx_ready_a[0], busy_a[0], par_clr_a[0], par_data_a[0]}), 32'b11000);
        @(negedge clk);
        #1 rst_n = 1'b1;
        rel = cyc;
        send(0, 9'h007, 1'b0, acc);
        check("accept_after_reset", 32'(acc - rel), 32'd1);
        wait_idle(0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_frame_fsm.md
# uart_tx_frame_fsm

Framing controller for the UART transmitter. It accepts a parallel byte over a valid/ready handshake and serialises it LSB-first as start, data, optional parity and stop bits at a fixed baud divisor. It sits directly upstream of the serial parity calculator: it pulses each data bit into the calculator, clears the calculator at frame start, and consumes its running XOR to drive the parity bit onto the line.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal 5..9.
- CLKS_PER_BIT, 16: clk cycles per line bit; legal ≥2.
- PARITY_EN, 1: 1 inserts a parity bit; 0 omits the parity state.
- PARITY_TYPE, 0: 0 = even, 1 = odd.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_WIDTH  byte to send; sampled only on acceptance.
- tx_valid  in  1  upstream has a byte.
- tx_ready  out  1  block can accept; high only in IDLE.
- tx_out  out  1  serial line, idle high.
- busy  out  1  high from acceptance through the last stop-bit cycle.
- par_clr  out  1  active-high synchronous clear to the parity calculator.
- par_data  out  1  one-cycle data-bit pulse to the parity calculator's data_in.
- par_in  in  1  running XOR from the parity calculator (1 = odd count of ones).

## Operation
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- Reset (async, reset=0) forces the following, from any state, aborting any frame in progress:
  - state=IDLE, tx_out=1, tx_ready=1, busy=0.
  - par_clr=0, par_data=0.
  - bit counter and baud counter = 0.
- IDLE:
  - tx_out=1.
  - Acceptance is tx_valid & tx_ready at a clk edge. On acceptance: latch tx_data into the shift register, move to START, and assert par_clr for exactly one cycle.
- START:
  - tx_out=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - tx_out = shift_reg[index] for CLKS_PER_BIT cycles per bit, LSB first.
  - par_data = shift_reg[index] during the first cycle of each data bit; par_data=0 in all other cycles and states.
  - After bit DATA_WIDTH-1: go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY:
  - tx_out = par_in ^ PARITY_TYPE, held for CLKS_PER_BIT cycles, then STOP.
- STOP:
  - tx_out=1 for CLKS_PER_BIT cycles, then IDLE.
- Handshake behaviour:
  - tx_valid is ignored while busy. Changes to tx_data after acceptance have no effect.
  - The block never accepts during STOP; tx_ready rises on the edge that enters IDLE.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit index is $clog2(DATA_WIDTH) bits. It resets to 0 on entering DATA.
- Parity calculator contract:
  - The calculator XORs data_in every clk. It must therefore see par_data=0 except on the DATA_WIDTH pulses.
  - par_in must be settled before PARITY begins.

## Timing
- Acceptance edge E: tx_out=0, busy=1, tx_ready=0 and par_clr=1 from E until E+1. The calculator clears at E+1.
- Data bit i occupies cycles E+(1+i)·CLKS_PER_BIT to E+(2+i)·CLKS_PER_BIT. Its par_data pulse occupies only the first of those cycles.
- The last pulse is registered into the calculator ≥CLKS_PER_BIT-1 cycles before PARITY, so par_in is stable through the whole parity bit.
- Frame length is (2 + DATA_WIDTH + PARITY_EN)·CLKS_PER_BIT cycles from E.
- With tx_valid held high, the minimum acceptance-to-acceptance period is frame length + 1. This gives exactly one extra idle-high cycle between frames.
- Reset deassertion: the first acceptance can occur on the first clk edge after reset goes high.

## Test plan
- Reset values: assert reset mid-DATA with CLKS_PER_BIT=4. Required within the same cycle, without waiting for clk: tx_out=1, tx_ready=1, busy=0, par_data=0, par_clr=0. The next tx_valid is accepted cleanly.
- Even parity, 0xA5, CLKS_PER_BIT=4. The line carries 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1. Each bit lasts 4 cycles; 44 busy cycles total. Exactly 8 par_data pulses, valued 1,0,1,0,0,1,0,1.
- Odd parity, 0xA5: the parity bit is 1. Even parity, 0x07: the parity bit is 1. Data 0x00, either type: the parity bit equals PARITY_TYPE.
- PARITY_EN=0, 0xFF: frame is start, 8×1, stop; busy for exactly 40 cycles; no PARITY state entered.
- Back-to-back: tx_valid held high with 0x3C then 0xC3. Second acceptance occurs exactly 45 cycles after the first. tx_data changes during frame 1 do not alter its bits. par_clr pulses once per frame, so the second parity bit is correct (even: 0).
- CLKS_PER_BIT=2, DATA_WIDTH=5, data 0x15: frame of 16 cycles. Bits are 1,0,1,0,1 and even parity is 1.
